store_merge_unit: RTL and testbench

STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

---
 rtl/store_merge_unit.sv | 129 ++++++++++++
 tb/tb_store_merge_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_merge_unit.sv
// Store merge unit: turns sb/sh/sw requests into full-word memory traffic.
// Sub-word stores do a read-modify-write of the containing word. Full-word
// stores write directly. Misaligned or reserved-size requests are rejected
// with a one-cycle pulse.
module store_merge_unit #(
    parameter int BIG_ENDIAN = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rd_data,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_data,
    output logic        done,
    output logic        misaligned
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, ERR} state_t;

    state_t      state_reg;
    logic [31:0] addr_reg;
    logic [31:0] data_reg;
    logic [1:0]  size_reg;

    logic        req_misaligned;
    logic [1:0]  lane_sel;
    logic        half_sel;
    logic [3:0]  lane_en;
    logic [31:0] ins_word;
    logic [31:0] merged_word;

    // Ready only while idle and not being held in reset.
    assign req_ready = (state_reg == IDLE) && !Reset;

    // Classify the incoming request: half needs addr[0]=0, word needs addr[1:0]=0.
    always_comb begin
        req_misaligned = 1'b0;
        case (req_size)
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = |req_addr[1:0];
            default: req_misaligned = 1'b1;
        endcase
    end

    // Pick which byte lanes of the read word the captured store overwrites.
    always_comb begin
        lane_sel = (BIG_ENDIAN != 0) ? (2'd3 - addr_reg[1:0]) : addr_reg[1:0];
        half_sel = (BIG_ENDIAN != 0) ? ~addr_reg[1] : addr_reg[1];
        ins_word = {4{data_reg[7:0]}};
        lane_en  = 4'b0001 << lane_sel;
        if (size_reg == 2'b01) begin
            ins_word = {2{data_reg[15:0]}};
            lane_en  = half_sel ? 4'b1100 : 4'b0011;
        end
    end

    // Per-lane merge: store bytes where enabled, read-back bytes elsewhere.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_word[8*gi +: 8] = lane_en[gi] ? ins_word[8*gi +: 8]
                                                        : mem_rd_data[8*gi +: 8];
        end
    endgenerate

    // Control FSM with registered strobes; reset aborts any operation in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            data_reg    <= '0;
            size_reg    <= '0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            done        <= 1'b0;
            misaligned  <= 1'b0;
        end else begin
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_reg <= req_addr;
                        data_reg <= req_data;
                        size_reg <= req_size;
                        if (req_misaligned) begin
                            state_reg  <= ERR;
                            misaligned <= 1'b1;
                        end else begin
                            mem_addr <= {req_addr[31:2], 2'b00};
                            if (req_size == 2'b10) begin
                                state_reg   <= WRITE;
                                mem_wr_en   <= 1'b1;
                                mem_wr_data <= req_data;
                                done        <= 1'b1;
                            end else begin
                                state_reg <= READ;
                                mem_rd_en <= 1'b1;
                            end
                        end
                    end
                end
                READ: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    state_reg   <= WRITE;
                    mem_wr_en   <= 1'b1;
                    mem_wr_data <= merged_word;
                    done        <= 1'b1;
                end
                WRITE:   state_reg <= IDLE;
                ERR:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Scoreboard bench for store_merge_unit: a byte-addressed reference memory
// predicts each store's outcome; a negedge monitor checks the DUT's strobes.
module tb_store_merge_unit;

    localparam int BE = 1;

    typedef struct {
        int          kind;   // 0 = sw write, 1 = read-modify-write, 2 = rejected
        logic [31:0] addr;
        logic [31:0] data;
        int          n;      // acceptance edge
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rd_data = '0;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic        done;
    logic        misaligned;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int mon_cyc;
    int deadline;
    exp_t head;
    exp_t exp_q[$];

    logic [31:0] mem_words [int unsigned];
    logic [7:0]  ref_bytes [int unsigned];

    store_merge_unit #(.BIG_ENDIAN(BE)) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .done(done), .misaligned(misaligned)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] init_word(input int unsigned idx);
        return (idx * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
    endfunction

    // Bit lane (0 = bits [7:0]) holding a given byte address within its word.
    function automatic int lane_of(input int unsigned a);
        int o;
        o = int'(a % 4);
        return (BE != 0) ? 3 - o : o;
    endfunction

    function automatic logic [7:0] ref_get(input int unsigned a);
        logic [31:0] w;
        if (ref_bytes.exists(a)) return ref_bytes[a];
        w = init_word(a / 4);
        return w[8*lane_of(a) +: 8];
    endfunction

    function automatic logic [31:0] ref_word(input int unsigned idx);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) w[8*lane_of(idx*4 + i) +: 8] = ref_get(idx*4 + i);
        return w;
    endfunction

    function automatic void preset(input logic [31:0] a, input logic [31:0] v);
        mem_words[a / 4] = v;
        for (int i = 0; i < 4; i++) ref_bytes[a + i] = v[8*lane_of(a + i) +: 8];
    endfunction

    // Reference model: apply the store to byte memory and queue the expectation.
    function automatic void model_push(input logic [31:0] a, input logic [31:0] d,
                                       input logic [1:0] s, input bit use_exp,
                                       input logic [31:0] exp_w, input int n);
        exp_t e;
        int nb;
        int sig;
        bit bad;
        e.n = n;
        e.addr = {a[31:2], 2'b00};
        e.data = '0;
        bad = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
        if (bad) begin
            e.kind = 2;
        end else begin
            nb = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
            for (int i = 0; i < nb; i++) begin
                sig = (BE != 0) ? (nb - 1 - i) : i;
                ref_bytes[a + i] = d[8*sig +: 8];
            end
            e.kind = (s == 2'b10) ? 0 : 1;
            e.data = use_exp ? exp_w : ref_word(a / 4);
            exp_done++;
        end
        exp_q.push_back(e);
    endfunction

    // Word memory seen by the DUT; read data valid only the cycle after a read strobe.
    always @(posedge Clk) begin
        if (mem_wr_en) mem_words[mem_addr / 4] = mem_wr_data;
        if (mem_rd_en)
            mem_rd_data <= mem_words.exists(mem_addr / 4) ? mem_words[mem_addr / 4]
                                                          : init_word(mem_addr / 4);
        else
            mem_rd_data <= $urandom;
    end

    // Monitor: compare every strobe against the head of the expectation queue.
    always @(negedge Clk) begin
        mon_cyc = edge_cnt + 1;
        chk("rd_wr_exclusive", {31'b0, mem_rd_en & mem_wr_en}, 32'd0);
        if (mem_rd_en) begin
            if (exp_q.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
            else begin
                chk("read_kind", exp_q[0].kind, 32'd1);
                chk("read_cycle", mon_cyc, exp_q[0].n + 1);
                chk("read_addr", mem_addr, exp_q[0].addr);
            end
        end
        if (mem_wr_en || done) begin
            if (done) done_cnt++;
            if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
            else begin
                head = exp_q.pop_front();
                chk("write_strobe", {31'b0, mem_wr_en}, 32'd1);
                chk("done_pulse", {31'b0, done}, 32'd1);
                chk("write_kind_not_err", {31'b0, head.kind == 2}, 32'd0);
                chk("write_cycle", mon_cyc, head.n + ((head.kind == 1) ? 3 : 1));
                chk("write_addr", mem_addr, head.addr);
                chk("write_data", mem_wr_data, head.data);
                $display("txn write addr=%h data=%h cycle=%0d", mem_addr, mem_wr_data, mon_cyc);
            end
        end
        if (misaligned) begin
            if (exp_q.size() == 0) chk("unexpected_misaligned", 32'd1, 32'd0);
            else begin
                head = exp_q.pop_front();
                chk("err_kind", head.kind, 32'd2);
                chk("err_cycle", mon_cyc, head.n + 1);
                chk("err_no_strobe", {29'b0, mem_rd_en, mem_wr_en, done}, 32'd0);
                $display("txn reject addr=%h cycle=%0d", head.addr, mon_cyc);
            end
        end
        if (exp_q.size() > 0) begin
            deadline = exp_q[0].n + ((exp_q[0].kind == 1) ? 3 : 1);
            if (mon_cyc > deadline) begin
                chk("response_timeout", mon_cyc, deadline);
                void'(exp_q.pop_front());
            end
        end
    end

    // Present a request once the unit is ready; optionally drive junk while busy.
    task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                             input bit junk, input bit use_exp, input logic [31:0] exp_w,
                             output int n);
        int waited;
        waited = 0;
        n = -1;
        while (!req_ready && waited < 20) begin
            if (junk) begin
                req_valid = 1'($urandom_range(0, 1));
                req_addr  = $urandom;
                req_data  = $urandom;
                req_size  = 2'($urandom_range(0, 3));
            end else begin
                req_valid = 1'b1;
                req_addr  = a;
                req_data  = d;
                req_size  = s;
            end
            @(negedge Clk);
            waited++;
        end
        if (!req_ready) begin
            chk("accept_timeout", {31'b0, req_ready}, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        n = edge_cnt + 1;
        model_push(a, d, s, use_exp, exp_w, n);
        @(negedge Clk);
    endtask

    initial begin
        int n;
        int n1;
        int n2;
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] d;
        int sel;
        logic [1:0] s;

        // Reset state
        repeat (3) @(negedge Clk);
        chk("reset_ready", {31'b0, req_ready}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_wr_data", mem_wr_data, 32'd0);
        chk("reset_strobes", {28'b0, mem_rd_en, mem_wr_en, done, misaligned}, 32'd0);
        Reset = 1'b0;
        #1;
        chk("ready_after_reset", {31'b0, req_ready}, 32'd1);

        // Directed cases
        drive_req(32'h0000_1008, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b1, 32'hDEAD_BEEF, n);
        req_valid = 1'b0;
        @(negedge Clk);
        preset(32'h0000_2000, 32'h1122_3344);
        drive_req(32'h0000_2002, 32'h0000_00AB, 2'b00, 1'b0, 1'b1, 32'h1122_AB44, n);
        req_valid = 1'b0;
        repeat (3) @(negedge Clk);
        preset(32'h0000_3000, 32'h1122_3344);
        drive_req(32'h0000_3000, 32'h0000_CAFE, 2'b01, 1'b0, 1'b1, 32'hCAFE_3344, n);
        req_valid = 1'b0;
        repeat (3) @(negedge Clk);
        drive_req(32'h0000_4001, 32'h1234_5678, 2'b10, 1'b0, 1'b0, 32'd0, n);
        req_valid = 1'b0;
        @(negedge Clk);
        drive_req(32'h0000_4003, 32'h0000_5678, 2'b01, 1'b0, 1'b0, 32'd0, n);
        req_valid = 1'b0;
        @(negedge Clk);

        // Back-to-back full-word stores with valid held high
        drive_req(32'h0000_1010, 32'hA5A5_0001, 2'b10, 1'b0, 1'b0, 32'd0, n1);
        drive_req(32'h0000_1014, 32'hA5A5_0002, 2'b10, 1'b0, 1'b0, 32'd0, n2);
        chk("b2b_accept_edge", n2, n1 + 2);
        req_valid = 1'b0;
        repeat (2) @(negedge Clk);

        // Reset while the byte store sits in WAIT
        drive_req(32'h0000_5002, 32'h0000_0077, 2'b00, 1'b0, 1'b0, 32'd0, n);
        req_valid = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        exp_q.delete();
        exp_done--;
        @(negedge Clk);
        chk("abort_ready_in_reset", {31'b0, req_ready}, 32'd0);
        chk("abort_no_write", {30'b0, mem_wr_en, done}, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        Reset = 1'b0;
        #1;
        chk("abort_ready_after", {31'b0, req_ready}, 32'd1);
        repeat (4) @(negedge Clk);

        // Random traffic with junk on the request bus while busy
        for (int t = 0; t < 300; t++) begin
            r = $urandom;
            a = r[0] ? (32'h0000_1000 + 32'($urandom_range(0, 31))) : $urandom;
            d = $urandom;
            sel = $urandom_range(0, 9);
            s = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            drive_req(a, d, s, 1'b1, 1'b0, 32'd0, n);
            if ($urandom_range(0, 2) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge Clk);
            end
        end
        req_valid = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge Clk);
        repeat (2) @(negedge Clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("done_count", done_cnt, exp_done);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
